// File: rtl/fetch_stage_if.sv
// fetch_stage_if: imem request/response, decode handshake and redirect signals of the fetch stage.
//   master: fetch stage side (drives imem_addr/imem_rmask and the if_* buffer outputs)
//   slave : environment side (drives imem_rdata/imem_resp, id_ready, redirect/redirect_pc)
interface fetch_stage_if;
   logic [31:0] imem_addr;
   logic [3:0]  imem_rmask;
   logic [31:0] imem_rdata;
   logic        imem_resp;
   logic        id_ready;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_pc_next;
   logic [31:0] if_inst;
   logic [63:0] if_order;
   modport master (
      output imem_addr, imem_rmask, if_valid, if_pc, if_pc_next, if_inst, if_order,
      input  imem_rdata, imem_resp, id_ready, redirect, redirect_pc
   );
   modport slave (
      input  imem_addr, imem_rmask, if_valid, if_pc, if_pc_next, if_inst, if_order,
      output imem_rdata, imem_resp, id_ready, redirect, redirect_pc
   );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch with one outstanding imem read and a single-entry decode buffer.
//   clk, rst : clock, synchronous active-high reset
//   bus      : imem request/response, decode valid/ready buffer, EX redirect, program-order index
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
   input logic           clk,
   input logic           rst,
   fetch_stage_if.master bus
);
   typedef enum logic [1:0] {REQ, WAIT, DISCARD} state_e;
   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        valid_q, valid_d;
   logic [31:0] if_pc_q, if_pc_d;
   logic [31:0] if_pc_next_q, if_pc_next_d;
   logic [31:0] if_inst_q, if_inst_d;
   logic [63:0] order_q, order_d;
   logic        issue, xfer;
   // A new read may only start when the buffer is free now or is being drained this cycle.
   assign issue = !rst && state_q == REQ && !bus.redirect && (!valid_q || bus.id_ready);
   assign xfer  = valid_q && bus.id_ready && !bus.redirect;
   assign bus.imem_addr  = {pc_q[31:2], 2'b00};
   assign bus.imem_rmask = issue ? 4'hF : 4'h0;
   assign bus.if_valid   = valid_q;
   assign bus.if_pc      = if_pc_q;
   assign bus.if_pc_next = if_pc_next_q;
   assign bus.if_inst    = if_inst_q;
   assign bus.if_order   = order_q;
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      valid_d      = valid_q && !xfer;
      if_pc_d      = if_pc_q;
      if_pc_next_d = if_pc_next_q;
      if_inst_d    = if_inst_q;
      order_d      = order_q + {63'd0, xfer};
      case (state_q)
         REQ:     state_d = issue ? WAIT : REQ;
         WAIT: begin
            if (bus.imem_resp) begin
               state_d = REQ;
               if (!bus.redirect) begin
                  valid_d      = 1'b1;
                  if_pc_d      = pc_q;
                  if_pc_next_d = pc_q + 32'd4;
                  if_inst_d    = bus.imem_rdata;
                  pc_d         = pc_q + 32'd4;
               end
            end else if (bus.redirect) begin
               // Wrong-path read still in flight: its response must be swallowed.
               state_d = DISCARD;
            end
         end
         DISCARD: state_d = bus.imem_resp ? REQ : DISCARD;
         default: state_d = REQ;
      endcase
      if (bus.redirect) begin
         pc_d    = bus.redirect_pc;
         valid_d = 1'b0;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= REQ;
         pc_q         <= RESET_PC;
         valid_q      <= 1'b0;
         if_pc_q      <= '0;
         if_pc_next_q <= '0;
         if_inst_q    <= '0;
         order_q      <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         valid_q      <= valid_d;
         if_pc_q      <= if_pc_d;
         if_pc_next_q <= if_pc_next_d;
         if_inst_q    <= if_inst_d;
         order_q      <= order_d;
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random stimulus for fetch_stage against a request/delivery scoreboard.
module tb_fetch_stage;
   localparam logic [31:0] RPC = 32'h1eceb000;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   fetch_stage_if bus();
   fetch_stage #(.RESET_PC(RPC)) dut (.clk(clk), .rst(rst), .bus(bus));
   int checks = 0;
   int errors = 0;
   // imem model
   bit          pend = 1'b0;
   bit          keep_stray = 1'b0;
   bit          force_en = 1'b0;
   int          cnt = 0;
   int          lat = 1;
   logic [31:0] force_val = '0;
   // reference model: next program-order PC, buffer contents, delivered count,
   // whether a read is in flight and whether its data still belongs to the current path
   logic [31:0] m_pc = RPC;
   logic [31:0] m_bpc = '0;
   logic [31:0] m_bpcn = '0;
   logic [31:0] m_binst = '0;
   logic [63:0] m_order = '0;
   bit          m_busy = 1'b0;
   bit          m_legit = 1'b0;
   bit          m_bvalid = 1'b0;
   // values observed in the last cycle
   logic [3:0]  o_rmask;
   logic [31:0] o_addr, o_pc, o_pcn, o_inst;
   logic [63:0] o_order;
   logic        o_valid;
   bit          any_valid;
   logic [63:0] snap;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      bit exp_issue;
      if (pend && cnt == 0) begin
         bus.imem_resp  = 1'b1;
         bus.imem_rdata = force_en ? force_val : $urandom;
         pend = 1'b0;
      end else begin
         bus.imem_resp  = 1'b0;
         bus.imem_rdata = $urandom;
         if (pend) cnt--;
      end
      #2;
      o_rmask = bus.imem_rmask;
      o_addr  = bus.imem_addr;
      o_valid = bus.if_valid;
      o_pc    = bus.if_pc;
      o_pcn   = bus.if_pc_next;
      o_inst  = bus.if_inst;
      o_order = bus.if_order;
      exp_issue = !rst && !m_busy && !bus.redirect && (!m_bvalid || bus.id_ready);
      chk("rmask", o_rmask, exp_issue ? 4'hF : 4'h0);
      if (exp_issue) chk("addr", o_addr, {m_pc[31:2], 2'b00});
      chk("if_valid", o_valid, m_bvalid);
      chk("if_pc", o_pc, m_bpc);
      chk("if_pc_next", o_pcn, m_bpcn);
      chk("if_inst", o_inst, m_binst);
      chk("if_order", o_order, m_order);
      if (rst) begin
         m_pc = RPC; m_bpc = '0; m_bpcn = '0; m_binst = '0; m_order = '0;
         m_busy = 1'b0; m_legit = 1'b0; m_bvalid = 1'b0;
      end else begin
         if (m_bvalid && bus.id_ready && !bus.redirect) begin
            m_bvalid = 1'b0;
            m_order++;
         end
         if (bus.imem_resp && m_busy) begin
            if (m_legit && !bus.redirect) begin
               m_bvalid = 1'b1;
               m_bpc    = m_pc;
               m_bpcn   = m_pc + 32'd4;
               m_binst  = bus.imem_rdata;
               m_pc     = m_pc + 32'd4;
            end
            m_busy  = 1'b0;
            m_legit = 1'b0;
         end
         if (exp_issue) begin
            m_busy  = 1'b1;
            m_legit = 1'b1;
         end
         if (bus.redirect) begin
            m_pc     = bus.redirect_pc;
            m_bvalid = 1'b0;
            m_legit  = 1'b0;
         end
      end
      if (rst && !keep_stray) pend = 1'b0;
      if (o_rmask == 4'hF) begin
         pend = 1'b1;
         cnt  = lat - 1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input int bound);
      bit found = 1'b0;
      any_valid = 1'b0;
      for (int i = 0; i < bound; i++) begin
         tick();
         any_valid |= o_valid;
         if (o_rmask == 4'hF) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      assert (found) else begin
         errors++;
         $error("FAIL wait_req observed no request expected one within %0d cycles", bound);
      end
   endtask

   task automatic wait_valid(input int bound);
      bit found = 1'b0;
      for (int i = 0; i < bound; i++) begin
         tick();
         if (o_valid) begin
            found = 1'b1;
            break;
         end
      end
      checks++;
      assert (found) else begin
         errors++;
         $error("FAIL wait_valid observed if_valid=0 expected 1 within %0d cycles", bound);
      end
   endtask

   initial begin
      bus.imem_resp = 1'b0; bus.imem_rdata = '0; bus.id_ready = 1'b1;
      bus.redirect = 1'b0; bus.redirect_pc = '0;
      @(posedge clk);
      #1;
      tick();
      rst = 1'b0;
      force_en = 1'b1; force_val = 32'h00000013;
      tick();
      chk("c0_rmask", o_rmask, 4'hF);
      chk("c0_addr", o_addr, RPC);
      tick();
      force_en = 1'b0;
      tick();
      chk("c2_valid", o_valid, 1'b1);
      chk("c2_pc", o_pc, RPC);
      chk("c2_pc_next", o_pcn, RPC + 32'd4);
      chk("c2_inst", o_inst, 32'h00000013);
      chk("c2_order", o_order, 64'd0);
      repeat (6) tick();
      chk("stream_pc3", o_pc, RPC + 32'hc);
      chk("stream_order3", o_order, 64'd3);
      tick();
      bus.id_ready = 1'b0;
      repeat (5) tick();
      chk("stall_valid", o_valid, 1'b1);
      chk("stall_pc", o_pc, RPC + 32'h10);
      bus.id_ready = 1'b1;
      tick();
      chk("unstall_rmask", o_rmask, 4'hF);
      chk("unstall_addr", o_addr, RPC + 32'h14);
      tick();
      chk("unstall_order", o_order, 64'd5);
      lat = 3;
      wait_req(10);
      bus.redirect = 1'b1; bus.redirect_pc = RPC + 32'h100;
      snap = m_order;
      tick();
      bus.redirect = 1'b0;
      lat = 2;
      wait_req(10);
      chk("rwait_addr", o_addr, RPC + 32'h100);
      chk("rwait_novalid", any_valid, 1'b0);
      chk("rwait_order", o_order, snap);
      tick();
      bus.redirect = 1'b1; bus.redirect_pc = 32'hfffffffc;
      snap = m_order;
      tick();
      bus.redirect = 1'b0;
      tick();
      chk("rresp_rmask", o_rmask, 4'hF);
      chk("rresp_addr", o_addr, 32'hfffffffc);
      chk("rresp_valid", o_valid, 1'b0);
      chk("rresp_order", o_order, snap);
      lat = 1;
      wait_valid(10);
      chk("wrap_pc0", o_pc, 32'hfffffffc);
      chk("wrap_pcn0", o_pcn, 32'h0);
      tick();
      wait_valid(10);
      chk("wrap_pc1", o_pc, 32'h0);
      chk("wrap_pcn1", o_pcn, 32'h4);
      bus.id_ready = 1'b0;
      wait_valid(10);
      tick();
      bus.id_ready = 1'b1;
      bus.redirect = 1'b1; bus.redirect_pc = RPC + 32'h203;
      snap = m_order;
      tick();
      bus.redirect = 1'b0;
      lat = 4;
      tick();
      chk("rfull_valid", o_valid, 1'b0);
      chk("rfull_order", o_order, snap);
      chk("rfull_rmask", o_rmask, 4'hF);
      chk("rfull_addr", o_addr, RPC + 32'h200);
      keep_stray = 1'b1;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      lat = 1;
      tick();
      chk("rstw_rmask", o_rmask, 4'hF);
      chk("rstw_addr", o_addr, RPC);
      keep_stray = 1'b0;
      tick();
      chk("rstw_stray_valid", o_valid, 1'b0);
      chk("rstw_order", o_order, 64'd0);
      for (int i = 0; i < 600; i++) begin
         int r;
         bus.id_ready = $urandom_range(0, 3) != 0;
         bus.redirect = $urandom_range(0, 9) == 0;
         r = $urandom_range(0, 7);
         bus.redirect_pc = r == 0 ? 32'hfffffffc : r == 1 ? 32'hfffffff8 : $urandom;
         lat = $urandom_range(1, 3);
         rst = i < 590 && $urandom_range(0, 99) == 0;
         tick();
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
